// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - fixed-priority, minimum-dwell arbiter feeding the four-digit seven-segment driver
// Optional build macro DISP_ARB_FLASH_ON_SWITCH_EN: force flashing for FLASH_CYCLES cycles after every grant change.
module display_arbiter #(
    parameter int DWELL_CYCLES = 100000000,
    parameter int CNT_W        = 27,
    parameter int FLASH_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [47:0] val_bus,
    input  logic [11:0] dots_bus,
    input  logic [2:0]  flash_bus,
    output logic [2:0]  gnt,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic [0:3]  dots,
    output logic        flashing,
    output logic        busy,
    output logic        switched
);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_OPEN} state_t;

    localparam int              DWELL_LOAD_I = (DWELL_CYCLES > 1) ? DWELL_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_LOAD_I);

    if (((longint'(DWELL_LOAD_I) >> CNT_W) != 0) ||
        ((FLASH_CYCLES > 1) && ((longint'(FLASH_CYCLES - 1) >> CNT_W) != 0))) begin : g_param_check
        $error("display_arbiter: CNT_W too narrow for DWELL_CYCLES or FLASH_CYCLES");
    end

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [15:0]      val_q, val_d;
    logic [0:3]       dots_q, dots_d;
    logic             flashing_q, flashing_d;
    logic             switched_q, switched_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [2:0]       top_req;
    logic             granted_req;
    logic             load;
    logic             clear;
    logic [2:0]       track_sel;
    logic [15:0]      sel_val;
    logic [0:3]       sel_dots;
    logic             sel_flash;
    logic             src_flash_d;
    logic             flash_hold;
    logic             flash_active;

`ifdef DISP_ARB_FLASH_ON_SWITCH_EN
    localparam int               FLASH_LOAD_I = (FLASH_CYCLES > 1) ? FLASH_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_LOAD_I);
    logic             src_flash_q;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
`endif

    always_comb begin
        top_req = 3'b000;
        if (req[2])      top_req = 3'b100;
        else if (req[1]) top_req = 3'b010;
        else if (req[0]) top_req = 3'b001;
        granted_req = |(req & gnt_q);

        state_d     = state_q;
        gnt_d       = gnt_q;
        dwell_cnt_d = dwell_cnt_q;
        switched_d  = 1'b0;
        load        = 1'b0;
        clear       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) load = 1'b1;
            end
            S_DWELL: begin
                if (dwell_cnt_q == '0) state_d = S_OPEN;
                else                   dwell_cnt_d = dwell_cnt_q - 1'b1;
            end
            S_OPEN: begin
                // One-hot codes are ordered by priority, so a numeric compare finds a higher requester
                if (top_req > gnt_q)            load  = 1'b1;
                else if (!granted_req && |req)  load  = 1'b1;
                else if (!granted_req)          clear = 1'b1;
            end
            default: clear = 1'b1;
        endcase

        if (load) begin
            gnt_d       = top_req;
            state_d     = S_DWELL;
            dwell_cnt_d = DWELL_LOAD;
            switched_d  = 1'b1;
        end
        if (clear) begin
            gnt_d       = 3'b000;
            state_d     = S_IDLE;
            dwell_cnt_d = '0;
        end
    end

    always_comb begin
        track_sel = load ? top_req : gnt_q;
        sel_val   = 16'h0000;
        sel_dots  = 4'b0000;
        sel_flash = 1'b0;
        case (track_sel)
            3'b100: begin sel_val = val_bus[47:32]; sel_dots = dots_bus[11:8]; sel_flash = flash_bus[2]; end
            3'b010: begin sel_val = val_bus[31:16]; sel_dots = dots_bus[7:4];  sel_flash = flash_bus[1]; end
            3'b001: begin sel_val = val_bus[15:0];  sel_dots = dots_bus[3:0];  sel_flash = flash_bus[0]; end
            default: begin sel_val = 16'h0000; sel_dots = 4'b0000; sel_flash = 1'b0; end
        endcase
    end

`ifdef DISP_ARB_FLASH_ON_SWITCH_EN
    assign flash_hold = src_flash_q;

    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (clear)                   flash_cnt_d = '0;
        else if (load)               flash_cnt_d = FLASH_LOAD;
        else if (flash_cnt_q != '0)  flash_cnt_d = flash_cnt_q - 1'b1;
        // The load cycle itself counts, giving FLASH_CYCLES visible cycles of forced flash
        flash_active = !clear && (load || (flash_cnt_q != '0));
    end
`else
    assign flash_hold   = flashing_q;
    assign flash_active = 1'b0;
`endif

    always_comb begin
        val_d       = val_q;
        dots_d      = dots_q;
        src_flash_d = flash_hold;
        if (clear) begin
            val_d       = 16'h0000;
            dots_d      = 4'b0000;
            src_flash_d = 1'b0;
        end else if (load || granted_req) begin
            val_d       = sel_val;
            dots_d      = sel_dots;
            src_flash_d = sel_flash;
        end
        flashing_d = src_flash_d | flash_active;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 3'b000;
            val_q       <= 16'h0000;
            dots_q      <= 4'b0000;
            flashing_q  <= 1'b0;
            switched_q  <= 1'b0;
            dwell_cnt_q <= '0;
`ifdef DISP_ARB_FLASH_ON_SWITCH_EN
            src_flash_q <= 1'b0;
            flash_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            val_q       <= val_d;
            dots_q      <= dots_d;
            flashing_q  <= flashing_d;
            switched_q  <= switched_d;
            dwell_cnt_q <= dwell_cnt_d;
`ifdef DISP_ARB_FLASH_ON_SWITCH_EN
            src_flash_q <= src_flash_d;
            flash_cnt_q <= flash_cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign A        = val_q[15:12];
    assign B        = val_q[11:8];
    assign C        = val_q[7:4];
    assign D        = val_q[3:0];
    assign dots     = dots_q;
    assign flashing = flashing_q;
    assign busy     = |gnt_q;
    assign switched = switched_q;

endmodule
